// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA sync generator.
package vga_pkg;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        BACK  = 2'd1,
        DISP  = 2'd2,
        FRONT = 2'd3
    } phase_t;

    localparam int CNT_W = 10;

    localparam int DEF_H_SYNC  = 96;
    localparam int DEF_H_BACK  = 48;
    localparam int DEF_H_DISP  = 640;
    localparam int DEF_H_FRONT = 16;
    localparam int DEF_V_SYNC  = 2;
    localparam int DEF_V_BACK  = 29;
    localparam int DEF_V_DISP  = 480;
    localparam int DEF_V_FRONT = 10;

    localparam int H_TOTAL = DEF_H_SYNC + DEF_H_BACK + DEF_H_DISP + DEF_H_FRONT;
    localparam int V_TOTAL = DEF_V_SYNC + DEF_V_BACK + DEF_V_DISP + DEF_V_FRONT;

    function automatic phase_t next_phase(input phase_t p);
        phase_t n;
        case (p)
            SYNC:    n = BACK;
            BACK:    n = DISP;
            DISP:    n = FRONT;
            FRONT:   n = SYNC;
            default: n = SYNC;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One sync axis: walks SYNC/BACK/DISP/FRONT with a per-phase counter, stepping on adv.
// The next-state values are exported so the top can register outputs with no added latency.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int P_SYNC  = 1,
    parameter int P_BACK  = 1,
    parameter int P_DISP  = 1,
    parameter int P_FRONT = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             adv,
    output phase_t           phase,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output phase_t           phase_nxt,
    output logic [CNT_W-1:0] count_nxt
);

    localparam logic [CNT_W-1:0] LAST_SYNC  = CNT_W'(P_SYNC - 1);
    localparam logic [CNT_W-1:0] LAST_BACK  = CNT_W'(P_BACK - 1);
    localparam logic [CNT_W-1:0] LAST_DISP  = CNT_W'(P_DISP - 1);
    localparam logic [CNT_W-1:0] LAST_FRONT = CNT_W'(P_FRONT - 1);

    phase_t           phase_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] last_s;
    logic             at_last_s;

    // Next-state decode: clear and move on at the last count of a phase.
    always_comb begin
        last_s = LAST_FRONT;
        case (phase_r)
            SYNC:    last_s = LAST_SYNC;
            BACK:    last_s = LAST_BACK;
            DISP:    last_s = LAST_DISP;
            FRONT:   last_s = LAST_FRONT;
            default: last_s = LAST_FRONT;
        endcase
        at_last_s = (count_r == last_s);
        wrap      = adv && at_last_s && (phase_r == FRONT);
        if (adv && at_last_s) begin
            phase_nxt = next_phase(phase_r);
            count_nxt = {CNT_W{1'b0}};
        end else if (adv) begin
            phase_nxt = phase_r;
            count_nxt = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            phase_nxt = phase_r;
            count_nxt = count_r;
        end
    end

    // Phase and counter state.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase_r <= SYNC;
            count_r <= {CNT_W{1'b0}};
        end else begin
            phase_r <= phase_nxt;
            count_r <= count_nxt;
        end
    end

    assign phase = phase_r;
    assign count = count_r;

endmodule

// File: rtl/vga_timing.sv
// 640x480@60 VGA sync generator at one pixel per two 50 MHz clocks.
// Outputs are registered from the axes' next state, so they track the state with no lag.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_SYNC  = DEF_H_SYNC,
    parameter int H_BACK  = DEF_H_BACK,
    parameter int H_DISP  = DEF_H_DISP,
    parameter int H_FRONT = DEF_H_FRONT,
    parameter int V_SYNC  = DEF_V_SYNC,
    parameter int V_BACK  = DEF_V_BACK,
    parameter int V_DISP  = DEF_V_DISP,
    parameter int V_FRONT = DEF_V_FRONT
) (
    input  logic       clock,
    input  logic       reset,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic [8:0] row,
    output logic [9:0] col,
    output logic       frame_end
);

    logic             pe_r;
    phase_t           h_phase, h_phase_nxt, v_phase, v_phase_nxt;
    logic [CNT_W-1:0] h_count, h_count_nxt, v_count, v_count_nxt;
    logic             h_wrap, v_wrap;
    logic             disp_s, front_entry_s;
    logic             hs_r, vs_r, blank_r, frame_end_r;
    logic [8:0]       row_r;
    logic [9:0]       col_r;
    logic             unused_s;

    // Pixel enable: low on the first clock after reset, then alternating.
    always_ff @(posedge clock) begin
        if (reset) begin
            pe_r <= 1'b0;
        end else begin
            pe_r <= ~pe_r;
        end
    end

    vga_axis_counter #(
        .P_SYNC (H_SYNC),
        .P_BACK (H_BACK),
        .P_DISP (H_DISP),
        .P_FRONT(H_FRONT)
    ) u_h_axis (
        .clock    (clock),
        .reset    (reset),
        .adv      (pe_r),
        .phase    (h_phase),
        .count    (h_count),
        .wrap     (h_wrap),
        .phase_nxt(h_phase_nxt),
        .count_nxt(h_count_nxt)
    );

    vga_axis_counter #(
        .P_SYNC (V_SYNC),
        .P_BACK (V_BACK),
        .P_DISP (V_DISP),
        .P_FRONT(V_FRONT)
    ) u_v_axis (
        .clock    (clock),
        .reset    (reset),
        .adv      (h_wrap),
        .phase    (v_phase),
        .count    (v_count),
        .wrap     (v_wrap),
        .phase_nxt(v_phase_nxt),
        .count_nxt(v_count_nxt)
    );

    // Visible-region and front-porch-entry decode from the upcoming axis state.
    always_comb begin
        disp_s        = (h_phase_nxt == DISP) && (v_phase_nxt == DISP);
        front_entry_s = (v_phase_nxt == FRONT) && (v_phase != FRONT);
    end

    // Output registers; a reset mid-frame also swallows any pending frame_end.
    always_ff @(posedge clock) begin
        if (reset) begin
            hs_r        <= 1'b0;
            vs_r        <= 1'b0;
            blank_r     <= 1'b1;
            row_r       <= 9'd0;
            col_r       <= 10'd0;
            frame_end_r <= 1'b0;
        end else begin
            hs_r        <= (h_phase_nxt != SYNC);
            vs_r        <= (v_phase_nxt != SYNC);
            blank_r     <= ~disp_s;
            row_r       <= disp_s ? v_count_nxt[8:0] : 9'd0;
            col_r       <= disp_s ? h_count_nxt : 10'd0;
            frame_end_r <= front_entry_s;
        end
    end

    assign hs        = hs_r;
    assign vs        = vs_r;
    assign blank     = blank_r;
    assign row       = row_r;
    assign col       = col_r;
    assign frame_end = frame_end_r;

    // Axis outputs this top has no use for.
    assign unused_s = ^{h_phase, h_count, v_count, v_count_nxt[CNT_W-1:9], v_wrap};

endmodule

// File: tb/tb_vga_timing.sv
// Randomised-reset bench for vga_timing: three parameter sets checked every clock
// against a frame-arithmetic reference model, plus edge-timing spot checks.
module tb_vga_timing;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       blank;
        logic       fe;
        logic [8:0] row;
        logic [9:0] col;
    } obs_t;

    localparam obs_t RST_OBS = '{hs: 1'b0, vs: 1'b0, blank: 1'b1, fe: 1'b0, row: 9'd0, col: 10'd0};

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic run_en = 1'b0;
    int   t = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic       d_hs, d_vs, d_blank, d_fe;
    logic [8:0] d_row;
    logic [9:0] d_col;
    logic       s_hs, s_vs, s_blank, s_fe;
    logic [8:0] s_row;
    logic [9:0] s_col;
    logic       m_hs, m_vs, m_blank, m_fe;
    logic [8:0] m_row;
    logic [9:0] m_col;

    obs_t obs_def, obs_tiny, obs_mid;
    assign obs_def  = {d_hs, d_vs, d_blank, d_fe, d_row, d_col};
    assign obs_tiny = {s_hs, s_vs, s_blank, s_fe, s_row, s_col};
    assign obs_mid  = {m_hs, m_vs, m_blank, m_fe, m_row, m_col};

    vga_timing u_def (
        .clock(clock), .reset(reset), .hs(d_hs), .vs(d_vs), .blank(d_blank),
        .row(d_row), .col(d_col), .frame_end(d_fe)
    );

    vga_timing #(
        .H_SYNC(1), .H_BACK(1), .H_DISP(4), .H_FRONT(1),
        .V_SYNC(1), .V_BACK(1), .V_DISP(3), .V_FRONT(1)
    ) u_tiny (
        .clock(clock), .reset(reset), .hs(s_hs), .vs(s_vs), .blank(s_blank),
        .row(s_row), .col(s_col), .frame_end(s_fe)
    );

    vga_timing #(
        .H_SYNC(5), .H_BACK(3), .H_DISP(12), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(3), .V_DISP(6), .V_FRONT(1)
    ) u_mid (
        .clock(clock), .reset(reset), .hs(m_hs), .vs(m_vs), .blank(m_blank),
        .row(m_row), .col(m_col), .frame_end(m_fe)
    );

    always #10 clock = ~clock;

    // Clocks since reset was last sampled high (clock 0 = first clock after release).
    always @(posedge clock) t <= reset ? 0 : t + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    // Reference: locate clock t within the frame and line, then apply the sync/porch rules.
    function automatic obs_t model(input int tc, input int hsy, input int hb, input int hd,
                                   input int hf, input int vsy, input int vb, input int vd,
                                   input int vf);
        obs_t m;
        int   lclk, fclk, f, line, pix;
        bit   hv, vv;
        lclk = 2 * (hsy + hb + hd + hf);
        fclk = lclk * (vsy + vb + vd + vf);
        f    = tc % fclk;
        line = f / lclk;
        pix  = (f % lclk) / 2;
        hv   = (pix >= hsy + hb) && (pix < hsy + hb + hd);
        vv   = (line >= vsy + vb) && (line < vsy + vb + vd);
        m.hs    = (pix >= hsy);
        m.vs    = (line >= vsy);
        m.blank = !(hv && vv);
        m.fe    = (f == lclk * (vsy + vb + vd));
        m.row   = (hv && vv) ? 9'(line - vsy - vb) : 9'd0;
        m.col   = (hv && vv) ? 10'(pix - hsy - hb) : 10'd0;
        return m;
    endfunction

    int   hs_low_cnt, hs_rise_t, hs_fall_t, bl_fall_t, bl_rise_t, col639_t, fall_row, fall_col;
    int   tiny_vis, mid_fe_seen, mid_fe_exp;
    logic p_hs = 1'b0;
    logic p_blank = 1'b1;
    logic p_mfe = 1'b0;

    initial begin
        obs_t me;
        mid_fe_seen = 0;
        mid_fe_exp  = 0;
        forever begin
            @(negedge clock);
            if (run_en) begin
                me = model(t, 5, 3, 12, 2, 2, 3, 6, 1);
                check_eq("def_outputs", 32'(obs_def), 32'(model(t, 96, 48, 640, 16, 2, 29, 480, 10)));
                check_eq("tiny_outputs", 32'(obs_tiny), 32'(model(t, 1, 1, 4, 1, 1, 1, 3, 1)));
                check_eq("mid_outputs", 32'(obs_mid), 32'(me));
                if (t == 0) begin
                    hs_low_cnt = 0; hs_rise_t = -1; hs_fall_t = -1; bl_fall_t = -1;
                    bl_rise_t = -1; col639_t = -1; fall_row = -1; fall_col = -1; tiny_vis = 0;
                end
                if (t < 1600 && !d_hs) hs_low_cnt++;
                if (t > 0 && d_hs && !p_hs && hs_rise_t < 0) hs_rise_t = t;
                if (t > 0 && !d_hs && p_hs && hs_fall_t < 0) hs_fall_t = t;
                if (t > 0 && !d_blank && p_blank && bl_fall_t < 0) begin
                    bl_fall_t = t;
                    fall_row  = int'(d_row);
                    fall_col  = int'(d_col);
                end
                if (t > 0 && d_blank && !p_blank && bl_fall_t >= 0 && bl_rise_t < 0) bl_rise_t = t;
                if (!d_blank && d_col == 10'd639 && col639_t < 0) col639_t = t;
                if (t < 84 && !s_blank) tiny_vis++;
                if (m_fe) check_eq("mid_fe_one_clock", 32'(p_mfe), 32'd0);
                mid_fe_seen += int'(m_fe);
                mid_fe_exp  += int'(me.fe);
                p_hs    = d_hs;
                p_blank = d_blank;
                p_mfe   = m_fe;
            end
        end
    end

    initial begin
        @(posedge clock);
        #1 run_en = 1'b1;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_eq("reset_state_def", 32'(obs_def), 32'(RST_OBS));
        check_eq("reset_state_mid", 32'(obs_mid), 32'(RST_OBS));

        // Past the end of the first visible line of the default timing.
        repeat (51300) @(negedge clock);
        check_eq("hs_low_clocks", hs_low_cnt, 192);
        check_eq("hs_rise_t", hs_rise_t, 192);
        check_eq("hs_next_fall_t", hs_fall_t, 1600);
        check_eq("blank_fall_t", bl_fall_t, 31 * 1600 + 288);
        check_eq("first_row", fall_row, 0);
        check_eq("first_col", fall_col, 0);
        check_eq("col639_t", col639_t, 31 * 1600 + 288 + 1278);
        check_eq("blank_rise_t", bl_rise_t, 31 * 1600 + 288 + 1280);
        check_eq("tiny_visible_clocks", tiny_vis, 24);

        // One-clock reset, then resets of random length at random points.
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(1500, 200)) @(negedge clock);
            reset = 1'b1;
            repeat ($urandom_range(3, 1)) @(negedge clock);
            reset = 1'b0;
        end
        repeat (2000) @(negedge clock);
        #1;
        check_eq("mid_fe_count", mid_fe_seen, mid_fe_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
